// File: rtl/register_file.sv
// Y86-style register file: 15 x DATA_WID registers, two combinational
// read ports (A, B) and two synchronous write ports (E, M).
module register_file #(
    parameter int DATA_WID = 64,
    parameter int ADDR_WID = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [DATA_WID-1:0] valE,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [DATA_WID-1:0] valM
);

    localparam logic [ADDR_WID-1:0] RNONE = '1;
    localparam int NREG = (1 << ADDR_WID) - 1;

    logic [DATA_WID-1:0] r_regs [NREG];

    logic w_wr_e;
    logic w_wr_m;

    assign w_wr_e = (destE != RNONE);
    assign w_wr_m = (destM != RNONE);

    // M is assigned last so it wins when both ports target one register
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_e) begin
                r_regs[destE] <= valE;
            end
            if (w_wr_m) begin
                r_regs[destM] <= valM;
            end
        end
    end

    assign valA = (srcA == RNONE) ? '0 : r_regs[srcA];
    assign valB = (srcB == RNONE) ? '0 : r_regs[srcB];

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an
// array-based reference model of the architectural registers.
module tb_register_file;

    localparam int DW = 64;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [AW-1:0] srcA = '0;
    logic [AW-1:0] srcB = '0;
    logic [DW-1:0] valA;
    logic [DW-1:0] valB;
    logic [AW-1:0] destE = 4'hF;
    logic [DW-1:0] valE = '0;
    logic [AW-1:0] destM = 4'hF;
    logic [DW-1:0] valM = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [15];

    register_file #(.DATA_WID(DW), .ADDR_WID(AW)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .srcA (srcA),
        .srcB (srcB),
        .valA (valA),
        .valB (valB),
        .destE(destE),
        .valE (valE),
        .destM(destM),
        .valM (valM)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] ref_rd(input int a);
        if (a >= 15) return '0;
        return model[a];
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Advance one edge; the model applies the architectural update rules.
    task automatic tick();
        if (RST) begin
            for (int i = 0; i < 15; i++) model[i] = '0;
        end else begin
            if (destE != 4'hF) model[destE] = valE;
            if (destM != 4'hF) model[destM] = valM;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 1'b0;
        destE = 4'hF;
        destM = 4'hF;
    endtask

    task automatic sweep_model(input string tag);
        for (int k = 0; k < 15; k++) begin
            srcA = k[AW-1:0];
            srcB = 4'(14 - k);
            #1;
            checks++;
            if (valA !== ref_rd(k)) begin
                errors++;
                $display("FAIL %s valA r%0d got %h exp %h",
                         tag, k, valA, ref_rd(k));
            end
            checks++;
            if (valB !== ref_rd(14 - k)) begin
                errors++;
                $display("FAIL %s valB r%0d got %h exp %h",
                         tag, 14 - k, valB, ref_rd(14 - k));
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 15; k++) begin
            destE = k[AW-1:0];
            valE = rnd64();
            tick();
        end
        RST = 1'b1;
        destE = 4'd2;
        valE = 64'hDEAD;
        destM = 4'd9;
        valM = 64'hBEEF;
        tick();
        idle();
        for (int k = 0; k < 15; k++) begin
            srcA = k[AW-1:0];
            srcB = 4'(14 - k);
            #1;
            checks++;
            if (valA !== 64'd0) begin
                errors++;
                $display("FAIL reset valA r%0d got %h exp 0", k, valA);
            end
            checks++;
            if (valB !== 64'd0) begin
                errors++;
                $display("FAIL reset valB r%0d got %h exp 0",
                         14 - k, valB);
            end
        end
    endtask

    task automatic test_single_writes();
        idle();
        for (int k = 0; k < 15; k++) begin
            destE = k[AW-1:0];
            valE = 64'(10 + 5 * k);
            tick();
        end
        idle();
        for (int k = 0; k < 15; k++) begin
            srcA = k[AW-1:0];
            srcB = 4'(14 - k);
            #1;
            checks++;
            if (valA !== 64'(10 + 5 * k)) begin
                errors++;
                $display("FAIL single valA r%0d got %h exp %h",
                         k, valA, 64'(10 + 5 * k));
            end
            checks++;
            if (valB !== 64'(10 + 5 * (14 - k))) begin
                errors++;
                $display("FAIL single valB r%0d got %h exp %h",
                         14 - k, valB, 64'(10 + 5 * (14 - k)));
            end
        end
    endtask

    task automatic test_dual_writes();
        destE = 4'd3;
        valE = 64'h1111;
        destM = 4'd12;
        valM = 64'h2222;
        tick();
        idle();
        srcA = 4'd3;
        srcB = 4'd12;
        #1;
        checks++;
        if (valA !== 64'h1111 || valB !== 64'h2222) begin
            errors++;
            $display("FAIL dual got %h/%h exp 1111/2222", valA, valB);
        end
        sweep_model("dual");
    endtask

    task automatic test_conflict();
        destE = 4'd5;
        valE = 64'hAAAA;
        destM = 4'd5;
        valM = 64'hBBBB;
        tick();
        idle();
        srcA = 4'd5;
        #1;
        checks++;
        if (valA !== 64'hBBBB) begin
            errors++;
            $display("FAIL conflict got %h exp bbbb", valA);
        end
        sweep_model("conflict");
    endtask

    task automatic test_rnone();
        for (int n = 0; n < 4; n++) begin
            destE = 4'hF;
            destM = 4'hF;
            valE = rnd64();
            valM = rnd64();
            tick();
        end
        idle();
        sweep_model("rnone_wr");
        srcA = 4'hF;
        srcB = 4'hF;
        #1;
        checks++;
        if (valA !== 64'd0 || valB !== 64'd0) begin
            errors++;
            $display("FAIL rnone_rd got %h/%h exp 0/0", valA, valB);
        end
    endtask

    task automatic test_read_before_write();
        destE = 4'd7;
        valE = 64'h55;
        tick();
        valE = 64'h99;
        srcA = 4'd7;
        #1;
        checks++;
        if (valA !== 64'h55) begin
            errors++;
            $display("FAIL rbw_pre got %h exp 55", valA);
        end
        tick();
        idle();
        #1;
        checks++;
        if (valA !== 64'h99) begin
            errors++;
            $display("FAIL rbw_post got %h exp 99", valA);
        end
        RST = 1'b1;
        destE = 4'd7;
        valE = 64'h77;
        tick();
        idle();
        #1;
        checks++;
        if (valA !== 64'd0) begin
            errors++;
            $display("FAIL rst_prio got %h exp 0", valA);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(0, 49) == 0);
            destE = 4'($urandom_range(0, 15));
            destM = ($urandom_range(0, 3) == 0) ? destE
                                                 : 4'($urandom_range(0, 15));
            valE = rnd64();
            valM = rnd64();
            srcA = 4'($urandom_range(0, 15));
            srcB = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (valA !== ref_rd(srcA) || valB !== ref_rd(srcB)) begin
                errors++;
                $display("FAIL random n%0d a%0d b%0d got %h/%h exp %h/%h",
                         n, srcA, srcB, valA, valB,
                         ref_rd(srcA), ref_rd(srcB));
            end
            tick();
        end
        idle();
        sweep_model("random_end");
    endtask

    initial begin
        for (int i = 0; i < 15; i++) model[i] = '0;
        #2;
        test_reset();
        test_single_writes();
        test_dual_writes();
        test_conflict();
        test_rnone();
        test_read_before_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Y86-style general-purpose register file for the CPU datapath.
- 15 architectural registers at addresses 0x0–0xE; address 0xF is the "no register" code (RNONE).
- Two combinational read ports (A, B) feed the decode stage.
- Two synchronous write ports (E = ALU result, M = memory result) are driven from the write-back stage.

Parameters:
- DATA_WID, 64, width of each register and of all data ports.
- ADDR_WID, 4, width of register addresses. 2^ADDR_WID - 1 is RNONE; 0 to 2^ADDR_WID - 2 are real registers.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous active-high reset.
- srcA  input  ADDR_WID  read address, port A.
- srcB  input  ADDR_WID  read address, port B.
- valA  output  DATA_WID  read data, port A.
- valB  output  DATA_WID  read data, port B.
- destE  input  ADDR_WID  write address, port E; RNONE = no write.
- valE  input  DATA_WID  write data, port E.
- destM  input  ADDR_WID  write address, port M; RNONE = no write.
- valM  input  DATA_WID  write data, port M.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Storage: 15 registers of DATA_WID bits. No storage exists for RNONE.

Reset:
- RST=1 at a rising CLK edge clears all 15 registers to 0.
- Reset has priority over both write ports; writes presented in that cycle are discarded.
- Reads stay combinational during reset, so valA/valB show 0 from the cycle after the reset edge.
- Deasserting RST mid-stream needs no recovery cycle; writes resume on the next edge.

Reads:
- Purely combinational, zero latency: valA = reg[srcA], valB = reg[srcB].
- A read from RNONE (0xF) returns 0.
- Reads return the contents before any write pending at the next edge. There is no internal write-to-read bypass; forwarding is the pipeline's job.
- valA and valB may address the same register and then return the same value.

Writes:
- On a rising CLK edge with RST=0:
  - if destE != RNONE, reg[destE] <= valE;
  - if destM != RNONE, reg[destM] <= valM.
- A write to RNONE is a no-op.
- Written data is visible on the read ports immediately after the edge, i.e. in the next cycle.
- Simultaneous write, same address (destE == destM != RNONE): port M wins; reg <= valM and valE is dropped.
- Simultaneous write, different addresses: both writes take effect in the same edge.

General rules:
- Register values are never altered except by reset or an explicit write.
- No arithmetic and no wrap-around; full DATA_WID values are stored unmodified.
- All-X or undriven inputs are not required to be tolerated.

Test Plan:
1. Reset clears: assert RST for one edge, then sweep srcA 0x0–0xE and srcB 0xE–0x0 -> valA = valB = 0 for every address.
2. Single-port writes:
   - For k = 0..14 write valE = 10+5k at destE = k with destM = 0xF.
   - Then read srcA = k -> valA = 10+5k.
   - Read srcB = 14-k -> valB = 10+5(14-k).
3. Dual distinct writes: destE=3/valE=0x1111 and destM=12/valM=0x2222 in one edge -> next cycle reg3 = 0x1111, reg12 = 0x2222, all other registers unchanged.
4. Write conflict: destE = destM = 5, valE=0xAAAA, valM=0xBBBB -> reg5 reads 0xBBBB.
5. RNONE handling:
   - destE = destM = 0xF with arbitrary data -> all 15 registers unchanged.
   - srcA = srcB = 0xF -> valA = valB = 0.
6. Read-before-write and reset priority:
   - Set reg7 = 0x55. Present destE=7/valE=0x99 with srcA=7 -> valA = 0x55 before the edge and 0x99 after it.
   - Then RST=1 together with destE=7/valE=0x77 -> reg7 = 0 after the edge.
